// File: rtl/snn_step_scheduler_if.sv
// ============================================================================
//  Module   : snn_step_scheduler_if
//  Purpose  : Bundles the control, configuration, stimulus and status signals
//             of the SNN timestep scheduler.
//  Modports : master - controller/testbench side (drives start, abort,
//                      configuration, stimulus, delay_tick and SNN outputs)
//             slave  - scheduler side (drives snn_enable, snn_spikes, busy,
//                      done, step_count, spike_count0, spike_count1)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface snn_step_scheduler_if #(
    parameter int SPIKE_W = 16,
    parameter int CNT_W   = 8
);
    // Control / configuration / stimulus
    logic               start;
    logic               abort;
    logic               cfg_valid;
    logic [CNT_W-1:0]   num_steps;
    logic [3:0]         settle_cycles;
    logic [SPIKE_W-1:0] spikes_in;
    logic               delay_tick;
    logic [1:0]         snn_spikes_out;

    // Scheduler outputs
    logic               snn_enable;
    logic [SPIKE_W-1:0] snn_spikes;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   step_count;
    logic [CNT_W-1:0]   spike_count0;
    logic [CNT_W-1:0]   spike_count1;

    modport master (
        output start, abort, cfg_valid, num_steps, settle_cycles,
               spikes_in, delay_tick, snn_spikes_out,
        input  snn_enable, snn_spikes, busy, done, step_count,
               spike_count0, spike_count1
    );

    modport slave (
        input  start, abort, cfg_valid, num_steps, settle_cycles,
               spikes_in, delay_tick, snn_spikes_out,
        output snn_enable, snn_spikes, busy, done, step_count,
               spike_count0, spike_count1
    );
endinterface

`default_nettype wire

// File: rtl/snn_step_scheduler.sv
// ============================================================================
//  Module   : snn_step_scheduler
//  Purpose  : Sequences a spiking neural network through a number of
//             timesteps. Each step waits for a rising edge of the divided
//             delay_tick, strobes the SNN for one cycle, lets it settle, then
//             samples the two output neurons into saturating spike counters.
//  Ports    : system_clock - only clock, rising edge
//             rst_n        - asynchronous active-low reset
//             bus          - snn_step_scheduler_if.slave (start/abort,
//                            configuration, stimulus, SNN strobe and status)
//  Options  : SNN_SCHED_ONESHOT_INPUT_EN - when defined, the stimulus is
//             cleared in the first SAMPLE of a run so it is presented for
//             step 1 only; otherwise it is held for the whole run.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module snn_step_scheduler #(
    parameter int SPIKE_W = 16,
    parameter int CNT_W   = 8
) (
    input  wire logic            system_clock,
    input  wire logic            rst_n,
    snn_step_scheduler_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_WAIT_TICK = 3'd2,
        S_RUN       = 3'd3,
        S_SETTLE    = 3'd4,
        S_SAMPLE    = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    state_t             state_q;
    logic               tick_q;
    logic [3:0]         settle_q;
    logic [3:0]         settle_cfg_q;
    logic               snn_enable_q;
    logic               busy_q;
    logic               done_q;
    logic [SPIKE_W-1:0] snn_spikes_q;
    logic [CNT_W-1:0]   step_count_q;
    logic [CNT_W-1:0]   spike_count0_q;
    logic [CNT_W-1:0]   spike_count1_q;

    // Next values computed outside the FSM block
    logic               tick_rise_d;
    logic [CNT_W-1:0]   step_count_d;
    logic [CNT_W-1:0]   spike_count0_d;
    logic [CNT_W-1:0]   spike_count1_d;

    // Edge detect against the copy registered on the previous cycle; an edge
    // that happened before WAIT_TICK was entered has already been absorbed
    // into tick_q and is therefore not seen.
    assign tick_rise_d    = bus.delay_tick & ~tick_q;
    assign step_count_d   = step_count_q + CNT_W'(1);
    assign spike_count0_d = (&spike_count0_q) ? spike_count0_q
                          : spike_count0_q + CNT_W'(bus.snn_spikes_out[0]);
    assign spike_count1_d = (&spike_count1_q) ? spike_count1_q
                          : spike_count1_q + CNT_W'(bus.snn_spikes_out[1]);

    always_ff @(posedge system_clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            tick_q         <= 1'b0;
            settle_q       <= 4'd0;
            settle_cfg_q   <= 4'd0;
            snn_enable_q   <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            snn_spikes_q   <= '0;
            step_count_q   <= '0;
            spike_count0_q <= '0;
            spike_count1_q <= '0;
        end else begin
            tick_q       <= bus.delay_tick;
            // Strobes default low; only the transitions into RUN / DONE raise them
            snn_enable_q <= 1'b0;
            done_q       <= 1'b0;

            if ((state_q != S_IDLE) && bus.abort) begin
                // Abort wins over everything; counters keep their values
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.start && bus.cfg_valid && (bus.num_steps != '0)) begin
                            state_q <= S_LOAD;
                            busy_q  <= 1'b1;
                        end
                    end
                    S_LOAD: begin
                        snn_spikes_q   <= bus.spikes_in;
                        step_count_q   <= '0;
                        spike_count0_q <= '0;
                        spike_count1_q <= '0;
                        // Settle length is frozen for the run
                        settle_cfg_q   <= bus.settle_cycles;
                        state_q        <= S_WAIT_TICK;
                    end
                    S_WAIT_TICK: begin
                        if (tick_rise_d) begin
                            state_q      <= S_RUN;
                            snn_enable_q <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        settle_q <= settle_cfg_q;
                        state_q  <= S_SETTLE;
                    end
                    S_SETTLE: begin
                        // A count of 0 or 1 both give a single SETTLE cycle
                        if (settle_q < 4'd2) begin
                            state_q <= S_SAMPLE;
                        end else begin
                            settle_q <= settle_q - 4'd1;
                        end
                    end
                    S_SAMPLE: begin
                        spike_count0_q <= spike_count0_d;
                        spike_count1_q <= spike_count1_d;
                        step_count_q   <= step_count_d;
`ifdef SNN_SCHED_ONESHOT_INPUT_EN
                        // Clearing on every SAMPLE is equivalent to clearing on
                        // the first one: later SAMPLEs find it already zero.
                        snn_spikes_q   <= '0;
`endif
                        // num_steps is compared live; a value already passed
                        // is only met again after step_count wraps.
                        if (step_count_d == bus.num_steps) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_WAIT_TICK;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.snn_enable   = snn_enable_q;
    assign bus.snn_spikes   = snn_spikes_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.step_count   = step_count_q;
    assign bus.spike_count0 = spike_count0_q;
    assign bus.spike_count1 = spike_count1_q;

endmodule

`default_nettype wire

// File: doc/snn_step_scheduler.md
SNN_STEP_SCHEDULER -- requirements
Module: snn_step_scheduler

Interface
REQ-001 SHALL have parameter SPIKE_W, default 16: width of the input spike vector presented to the SNN.
REQ-002 SHALL have parameter CNT_W, default 8: width of the step counter and of each output spike counter.
REQ-003 SHALL have port system_clock, input, 1: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port start, input, 1: request a run; sampled only in IDLE.
REQ-006 SHALL have port abort, input, 1: terminate the run immediately.
REQ-007 SHALL have port cfg_valid, input, 1: configuration is stable (already synchronized to system_clock).
REQ-008 SHALL have port num_steps, input, CNT_W: number of timesteps per run.
REQ-009 SHALL have port settle_cycles, input, 4: number of idle cycles after each SNN evaluation before sampling.
REQ-010 SHALL have port spikes_in, input, SPIKE_W: stimulus vector.
REQ-011 SHALL have port delay_tick, input, 1: divided timestep clock, used as data and rising-edge detected.
REQ-012 SHALL have port snn_spikes_out, input, 2: SNN output spikes.
REQ-013 SHALL have port snn_enable, output, 1: SNN evaluation strobe.
REQ-014 SHALL have port snn_spikes, output, SPIKE_W: latched stimulus driven to the SNN.
REQ-015 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-016 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-017 SHALL have port step_count, output, CNT_W: number of completed steps.
REQ-018 SHALL have ports spike_count0 and spike_count1, output, CNT_W each: per-output-neuron spike totals.

Function
REQ-019 SHALL implement the states IDLE, LOAD, WAIT_TICK, RUN, SETTLE, SAMPLE and DONE.
REQ-020 IDLE -> LOAD SHALL occur when start=1, cfg_valid=1 and num_steps!=0; otherwise it SHALL remain in IDLE.
REQ-021 LOAD SHALL last one cycle: latch spikes_in into snn_spikes, clear step_count and both spike counters, then go to WAIT_TICK.
REQ-022 Rising-edge detection SHALL use one registered copy of delay_tick; an edge is delay_tick=1 while the registered copy is 0.
REQ-023 WAIT_TICK -> RUN SHALL occur on the first cycle a rising edge is detected; an edge that occurred before entry SHALL be ignored.
REQ-024 RUN SHALL last exactly one cycle with snn_enable=1; snn_enable SHALL be 0 in every other state.
REQ-025 SETTLE SHALL hold for settle_cycles cycles, counted by an internal down-counter; settle_cycles=0 SHALL go directly to SAMPLE after one SETTLE cycle.
REQ-026 SAMPLE SHALL last one cycle and SHALL:
  - add snn_spikes_out[0] to spike_count0 and snn_spikes_out[1] to spike_count1, each saturating at all-ones;
  - increment step_count.
REQ-027 SAMPLE SHALL go to DONE when the incremented step_count equals num_steps; otherwise it SHALL go to WAIT_TICK.
REQ-028 DONE SHALL last one cycle with done=1, then go to IDLE; counters SHALL hold their values until the next LOAD.
REQ-029 Latency from start to the RUN state SHALL be 2 cycles plus the wait for the delay_tick edge.
REQ-030 abort=1 in any state other than IDLE SHALL force IDLE on the next edge, with no done pulse and counters held.
REQ-031 abort SHALL take priority over every other transition.
REQ-032 Changes to num_steps, settle_cycles or spikes_in during a run SHALL be ignored except as follows:
  - num_steps is compared live in SAMPLE;
  - a value below step_count+1 SHALL run until step_count wraps.

Reset
REQ-033 rst_n=0 SHALL asynchronously force the following:
  - state IDLE;
  - snn_enable, busy and done to 0;
  - snn_spikes, step_count, spike_count0, spike_count1, the settle counter and the edge register to 0.
REQ-034 Reset asserted mid-run SHALL abandon the run without a done pulse.

Configuration
REQ-035 Macro SNN_SCHED_ONESHOT_INPUT_EN, when defined, SHALL clear snn_spikes to 0 in the first SAMPLE of a run, so the stimulus is presented for step 1 only.
REQ-036 Without SNN_SCHED_ONESHOT_INPUT_EN, snn_spikes SHALL hold the LOAD value for the whole run.

Verification
REQ-037 Basic run: num_steps=3, settle_cycles=2, snn_spikes_out=2'b01 held, delay_tick period 10 cycles, start pulse -> exactly 3 snn_enable pulses, each 1 cycle, one per tick edge; done pulse once; step_count=3, spike_count0=3, spike_count1=0.
REQ-038 Start guard: start with cfg_valid=0, or with num_steps=0 -> state stays IDLE, busy=0, no snn_enable.
REQ-039 Saturation: CNT_W=8, num_steps=255, snn_spikes_out=2'b11 -> both spike counters=255 with no wrap; step_count=255; done pulses once.
REQ-040 Abort: abort asserted during SETTLE of step 2 -> IDLE next cycle, busy=0, no done pulse, step_count=1.
REQ-041 Reset mid-run: rst_n low during WAIT_TICK -> all outputs 0 asynchronously before the next clock edge.
REQ-042 Macro: spikes_in=16'hA5A5, num_steps=2 -> snn_spikes=16'hA5A5 during step 1 in both builds; during step 2 it is 16'h0000 with the macro defined and 16'hA5A5 without it.
